bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It is the upstream stage of the BCD-to-excess-3 code converter and supplies its packed 4-bit BCD digits. Input and output both use valid/ready handshakes. It is single-buffered, with one conversion in flight.

Parameters:
- BIN_W, 8, width of binary input.
- DIGITS, 3, number of BCD output digits. Elaboration error unless 10^DIGITS > 2^BIN_W - 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bin is valid.
- in_ready  output  1  block can accept a value.
- in_bin  input  BIN_W  unsigned binary value.
- out_valid  output  1  bcd_out holds a completed result.
- out_ready  input  1  downstream consumes the result.
- bcd_out  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, bcd_out=0, internal shift/digit registers=0, cycle counter=0.
- in_ready = (state==IDLE), decoded from state only, so it reads 1 during and after reset. There is no combinational path from in_valid or out_ready to in_ready.
- IDLE: on an edge with in_valid & in_ready, capture in_bin into the shift register, clear the digit register and counter, and go to CONV.
- CONV: each edge does the following, in this order:
  - every digit >= 5 gets +3 (4-bit add; cannot overflow);
  - the {digits, shift register} concatenation shifts left 1;
  - the counter increments.
- After BIN_W CONV edges: load bcd_out with the final digits, set out_valid=1, go to HOLD.
- Latency: out_valid rises exactly BIN_W cycles after the accept edge (8 for defaults).
- HOLD: out_valid=1, and bcd_out stays stable until an edge with out_ready=1. On that edge, out_valid goes to 0 and the state goes to IDLE. bcd_out keeps its last value while IDLE/CONV and is meaningful only when out_valid=1.
- Throughput: at most one conversion per BIN_W+2 cycles when out_ready is held high.
- in_valid while busy: ignored and not sampled. Upstream must hold its data until in_ready.
- out_ready while out_valid=0: no effect.
- Reset mid-CONV or mid-HOLD: conversion aborted, no output produced, result discarded.
- Invariant: every bcd_out digit is in 0..9 whenever out_valid=1.

Optional Feature:
- Macro: BIN_TO_BCD_XS3_EN.
- Defined:
  - adds output port xs3_out (4*DIGITS bits);
  - each nibble is the matching bcd_out digit +3 (excess-3);
  - registered with bcd_out, same timing and reset value 0.
- Undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package bcd_pkg:
  - state typedef (IDLE, CONV, HOLD);
  - DIGIT_W=4, ADD3_THRESH=5, XS3_BIAS=3.
- Sub-module bcd_add3_digit:
  - combinational, 4-bit in/out;
  - output = in + 3 if in >= 5, else in;
  - instantiated DIGITS times via generate.

Test Plan:
- Zero input: in_bin=8'd0 accepted at edge E -> out_valid=1 at E+8, bcd_out=12'h000, busy=0 after out_ready.
- Maximum input: in_bin=8'd255 -> bcd_out=12'h255. With BIN_TO_BCD_XS3_EN, xs3_out=12'h588.
- Backpressure: in_bin=8'd99, out_ready=0 for 5 cycles -> bcd_out=12'h099 stable, in_ready=0. A second in_valid with 8'd42 during HOLD is ignored. Then 8'd42 is accepted after release and gives 12'h042.
- Back-to-back: 8'd9 then 8'd10 with out_ready=1 -> results 12'h009 then 12'h010, in order. Second accept occurs exactly 10 cycles after the first.
- Reset mid-operation: rst_n low 4 cycles after accepting 8'd200 -> out_valid stays 0, in_ready=1. After release, 8'd37 gives 12'h037.
- Exhaustive sweep: all 0..255 compared against a behavioural model. Every digit <= 9 and latency is 8 for each.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// bcd_pkg: shared state encoding, digit constants and elaboration helpers
// for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        HOLD
    } state_t;

    localparam int DIGIT_W     = 4;
    localparam int ADD3_THRESH = 5;
    localparam int XS3_BIAS    = 3;

    // True when DIGITS decimal digits can represent every BIN_W-bit value.
    function automatic bit digits_cover(input int unsigned bin_w, input int unsigned digits);
        longint unsigned p10;
        longint unsigned max_bin;
        p10 = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p10 = p10 * 10;
        end
        max_bin = (longint'(1) << bin_w) - 1;
        return p10 > max_bin;
    endfunction

    // Excess-3 code of one BCD digit.
    function automatic logic [DIGIT_W-1:0] xs3_digit(input logic [DIGIT_W-1:0] d);
        return d + DIGIT_W'(XS3_BIAS);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Handshake bundle between the converter and its upstream/downstream.
// BIN_TO_BCD_XS3_EN adds the excess-3 result bus xs3_out.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  busy;
`ifdef BIN_TO_BCD_XS3_EN
    logic [4*DIGITS-1:0]   xs3_out;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, bcd_out, busy, xs3_out
    );
    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, bcd_out, busy, xs3_out
    );
`else
    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, bcd_out, busy
    );
    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, bcd_out, busy
    );
`endif
endinterface

// File: rtl/bin_to_bcd_seq_add3_digit.sv
// bcd_add3_digit: double-dabble digit correction, +3 when the digit is >= 5.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Correct the digit before the shift so it carries into the next decade.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= DIGIT_W'(ADD3_THRESH)) begin
            digit_out = digit_in + DIGIT_W'(XS3_BIAS);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-bit-per-clock binary-to-BCD converter (double dabble)
// with valid/ready on both sides and a single conversion in flight.
// Optional macro BIN_TO_BCD_XS3_EN adds a registered excess-3 copy xs3_out.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    bin_to_bcd_seq_if.slave bus
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (!digits_cover(BIN_W, DIGITS)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t             state;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   digits;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   digits_next;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd_q;
    logic               out_valid_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_in  (digits[g*DIGIT_W +: DIGIT_W]),
            .digit_out (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected digits shifted left by one, taking in the next binary MSB.
    assign digits_next = {adj[BCD_W-2:0], shreg[BIN_W-1]};

`ifdef BIN_TO_BCD_XS3_EN
    logic [BCD_W-1:0] xs3_next;
    logic [BCD_W-1:0] xs3_q;

    // Excess-3 view of the result that is about to be loaded.
    always_comb begin
        xs3_next = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            xs3_next[i*DIGIT_W +: DIGIT_W] = xs3_digit(digits_next[i*DIGIT_W +: DIGIT_W]);
        end
    end
`endif

    // Control FSM plus datapath: accept, BIN_W shift steps, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            digits      <= '0;
            cnt         <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
`ifdef BIN_TO_BCD_XS3_EN
            xs3_q       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        shreg  <= bus.in_bin;
                        digits <= '0;
                        cnt    <= '0;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    digits <= digits_next;
                    shreg  <= {shreg[BIN_W-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        bcd_q       <= digits_next;
                        out_valid_q <= 1'b1;
                        state       <= HOLD;
`ifdef BIN_TO_BCD_XS3_EN
                        xs3_q       <= xs3_next;
`endif
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.bcd_out   = bcd_q;
`ifdef BIN_TO_BCD_XS3_EN
    assign bus.xs3_out   = xs3_q;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (default 8-bit / 3 digits).
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   cyc;

    logic [7:0]  acc_q[$];
    int          acc_cyc[$];
    logic [11:0] out_q[$];

    bin_to_bcd_seq_if #(.BIN_W(8), .DIGITS(3)) bus ();

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log accepted inputs and consumed outputs at each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && bus.in_valid && bus.in_ready) begin
            acc_q.push_back(bus.in_bin);
            acc_cyc.push_back(cyc);
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            out_q.push_back(bus.bcd_out);
        end
    end

    function automatic logic [11:0] bcd_model(input int v);
        logic [11:0] r;
        int d;
        d = v;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[i*4 +: 4] = 4'(d % 10);
            d = d / 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] xs3_model(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        return r;
    endfunction

    // Present v and return at the falling edge following its accept edge.
    task automatic accept_one(input logic [7:0] v, output bit ok);
        int n;
        n  = acc_q.size();
        ok = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_bin   = v;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (acc_q.size() > n) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    // Count cycles (from the accept edge) until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.bcd_out !== 12'h000) begin n_err++; $display("FAIL reset_bcd got=%h exp=000", bus.bcd_out); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_zero();
        bit ok; int lat;
        accept_one(8'd0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL zero_accept got=%b exp=1", ok); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL zero_busy got=%b exp=1", bus.busy); end
        wait_out(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL zero_latency got=%0d exp=8", lat); end
        n_cmp++; if (bus.bcd_out !== 12'h000) begin n_err++; $display("FAIL zero_bcd got=%h exp=000", bus.bcd_out); end
        consume();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL zero_drop_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_after got=%b exp=0", bus.busy); end
    endtask

    task automatic test_max();
        bit ok; int lat;
        accept_one(8'd255, ok);
        wait_out(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL max_latency got=%0d exp=8", lat); end
        n_cmp++; if (bus.bcd_out !== 12'h255) begin n_err++; $display("FAIL max_bcd got=%h exp=255", bus.bcd_out); end
`ifdef BIN_TO_BCD_XS3_EN
        n_cmp++; if (bus.xs3_out !== 12'h588) begin n_err++; $display("FAIL max_xs3 got=%h exp=588", bus.xs3_out); end
`endif
        consume();
    endtask

    task automatic test_backpressure();
        bit ok; int lat; int n_acc; bit stable;
        accept_one(8'd99, ok);
        wait_out(lat);
        n_cmp++; if (bus.bcd_out !== 12'h099) begin n_err++; $display("FAIL bp_bcd got=%h exp=099", bus.bcd_out); end
        n_acc = acc_q.size();
        bus.in_valid = 1'b1;
        bus.in_bin   = 8'd42;
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.bcd_out !== 12'h099 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
        end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL bp_hold_stable got=%h/%b/%b exp=099/1/0", bus.bcd_out, bus.out_valid, bus.in_ready); end
        n_cmp++; if (acc_q.size() !== n_acc) begin n_err++; $display("FAIL bp_ignored_in_hold got=%0d exp=%0d", acc_q.size(), n_acc); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_cmp++; if (acc_q.size() !== n_acc + 1) begin n_err++; $display("FAIL bp_accept_count got=%0d exp=%0d", acc_q.size(), n_acc + 1); end
        else begin
            n_cmp++; if (acc_q[n_acc] !== 8'd42) begin n_err++; $display("FAIL bp_accept_val got=%0d exp=42", acc_q[n_acc]); end
        end
        wait_out(lat);
        n_cmp++; if (bus.bcd_out !== 12'h042) begin n_err++; $display("FAIL bp_second_bcd got=%h exp=042", bus.bcd_out); end
        consume();
    endtask

    task automatic test_back_to_back();
        int n_acc; int n_out; int k;
        n_acc = acc_q.size();
        n_out = out_q.size();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_bin    = 8'd9;
        for (k = 0; k < 40 && acc_q.size() < n_acc + 1; k++) @(negedge clk);
        bus.in_bin = 8'd10;
        for (k = 0; k < 40 && acc_q.size() < n_acc + 2; k++) @(negedge clk);
        bus.in_valid = 1'b0;
        for (k = 0; k < 40 && out_q.size() < n_out + 2; k++) @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++; if (out_q.size() !== n_out + 2 || acc_q.size() !== n_acc + 2) begin
            n_err++; $display("FAIL b2b_counts got=%0d/%0d exp=%0d/%0d", acc_q.size(), out_q.size(), n_acc + 2, n_out + 2);
        end else begin
            n_cmp++; if (acc_cyc[n_acc+1] - acc_cyc[n_acc] !== 10) begin n_err++; $display("FAIL b2b_spacing got=%0d exp=10", acc_cyc[n_acc+1] - acc_cyc[n_acc]); end
            n_cmp++; if (out_q[n_out] !== 12'h009) begin n_err++; $display("FAIL b2b_first got=%h exp=009", out_q[n_out]); end
            n_cmp++; if (out_q[n_out+1] !== 12'h010) begin n_err++; $display("FAIL b2b_second got=%h exp=010", out_q[n_out+1]); end
        end
    endtask

    task automatic test_reset_mid();
        bit ok; int lat; bit quiet;
        accept_one(8'd200, ok);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rmid_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_in_ready got=%b exp=1", bus.in_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
        end
        n_cmp++; if (quiet !== 1'b1) begin n_err++; $display("FAIL rmid_no_output got=%b exp=1", quiet); end
        accept_one(8'd37, ok);
        wait_out(lat);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL rmid_latency got=%0d exp=8", lat); end
        n_cmp++; if (bus.bcd_out !== 12'h037) begin n_err++; $display("FAIL rmid_bcd got=%h exp=037", bus.bcd_out); end
        consume();
    endtask

    task automatic test_sweep();
        bit ok; int lat; logic [11:0] exp_bcd; bit dig_ok;
        for (int v = 0; v < 256; v++) begin
            exp_bcd = bcd_model(v);
            accept_one(8'(v), ok);
            wait_out(lat);
            n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL sweep_latency v=%0d got=%0d exp=8", v, lat); end
            n_cmp++; if (bus.bcd_out !== exp_bcd) begin n_err++; $display("FAIL sweep_bcd v=%0d got=%h exp=%h", v, bus.bcd_out, exp_bcd); end
            dig_ok = 1'b1;
            for (int i = 0; i < 3; i++) if (bus.bcd_out[i*4 +: 4] > 4'd9) dig_ok = 1'b0;
            n_cmp++; if (dig_ok !== 1'b1) begin n_err++; $display("FAIL sweep_digit_range v=%0d got=%h exp=digits<=9", v, bus.bcd_out); end
`ifdef BIN_TO_BCD_XS3_EN
            n_cmp++; if (bus.xs3_out !== xs3_model(exp_bcd)) begin n_err++; $display("FAIL sweep_xs3 v=%0d got=%h exp=%h", v, bus.xs3_out, xs3_model(exp_bcd)); end
`endif
            consume();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        bus.in_valid  = 1'b0;
        bus.in_bin    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_zero();
        test_max();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
